// File: rtl/mux4x16_pkg.sv
// mux4x16_pkg: shared width default and select codes for the 4:1 datapath selector
package mux4x16_pkg;
    localparam int WIDTH_DEF = 16;
    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;
endpackage

// File: rtl/mux4x16_mux4.sv
// mux4: combinational WIDTH-bit 4:1 selector
module mux4
    import mux4x16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb y = (s == SEL_A) ? a : (s == SEL_B) ? b : (s == SEL_C) ? c : d;
endmodule

// File: rtl/mux4x16.sv
// mux4x16: 4:1 WIDTH-bit selector with registered output and sync reset
module mux4x16
    import mux4x16_pkg::*;
#(
    parameter int               WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] O
);
    logic [WIDTH-1:0] sel;
    mux4 #(.WIDTH(WIDTH)) u_mux4 (.a(A), .b(B), .c(C), .d(D), .s(s), .y(sel));
    always_ff @(posedge CLK)
        O <= Reset ? RESET_VAL : sel;
endmodule

// File: tb/tb_mux4x16.sv
// tb_mux4x16: directed-vector bench for the registered 4:1 selector
module tb_mux4x16;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b, c, d, o;
    logic [1:0]  s;
    int          n_checks = 0;
    int          n_fail = 0;

    mux4x16 dut (.CLK(clk), .Reset(rst), .A(a), .B(b), .C(c), .D(d), .s(s), .O(o));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_sweep [4];
        rst = 1'b1; a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4; s = 2'd0;
        tick();
        check("reset", o, 16'h0000);
        rst = 1'b0;
        exp_sweep = '{16'd1, 16'd2, 16'd3, 16'd4};
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #2 check("sweep_hold", o, i == 0 ? 16'h0000 : exp_sweep[i-1]);
            tick();
            check("sweep", o, exp_sweep[i]);
        end
        a = 16'hFFFF; b = 16'h8001; c = 16'h0000; d = 16'h5A5A;
        exp_sweep = '{16'hFFFF, 16'h8001, 16'h0000, 16'h5A5A};
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            tick();
            check("full_data", o, exp_sweep[i]);
        end
        a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4; s = 2'd3;
        tick();
        check("pre_reset", o, 16'd4);
        #2 rst = 1'b1;
        #1 check("reset_async_ignored", o, 16'd4);
        tick();
        check("reset_mid", o, 16'h0000);
        rst = 1'b0; s = 2'd1;
        tick();
        check("after_reset", o, 16'd2);
        s = 2'd0;
        tick();
        check("reg_s0", o, 16'd1);
        #3 s = 2'd2;
        #1 check("reg_hold_s", o, 16'd1);
        tick();
        check("reg_s2", o, 16'd3);
        s = 2'd1;
        tick();
        check("reg_s1", o, 16'd2);
        #2 d = 16'hBEEF;
        #1 check("reg_d_mid", o, 16'd2);
        tick();
        check("reg_d_edge", o, 16'd2);
        s = 2'd2; c = 16'h1234;
        tick();
        check("simul", o, 16'h1234);
        s = 2'd3;
        tick();
        check("new_d", o, 16'hBEEF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux4x16.md
Name: mux4x16

Overview:
- 4-input, 16-bit-wide selector with a registered output, used in the ALU integration datapath to pick one of four operand/result buses.
- A 2-bit select `s` chooses among inputs A, B, C and D.
- The chosen word is captured on the rising clock edge and presented on O.
- One clock domain; synchronous, active-high reset.

Parameters:
- WIDTH, 16, data width of A, B, C, D and O.
- RESET_VAL, 0, value loaded into O on reset.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset; sampled on the rising edge of CLK.
- A  input  WIDTH  data input, selected when s = 0.
- B  input  WIDTH  data input, selected when s = 1.
- C  input  WIDTH  data input, selected when s = 2.
- D  input  WIDTH  data input, selected when s = 3.
- s  input  2  select code.
- O  output  WIDTH  registered selected data.

Behaviour:
- Selection function: sel = A when s=2'b00, B when s=2'b01, C when s=2'b10, D when s=2'b11.
- Select must be a full case; no latch, no X propagation for legal 2-bit codes.
- On each rising edge of CLK:
  - if Reset=1: O <= RESET_VAL (0).
  - else: O <= sel.
- Reset has priority over data. Reset is synchronous only; asserting it between edges has no effect until the next edge.
- Latency: exactly 1 cycle from A/B/C/D/s change (stable before an edge) to O.
  - No combinational path from any input to O.
- O holds its value between edges. Input changes between edges are not visible until the next edge.
- Power-up: O is undefined until the first edge with Reset=1. The bench must reset before checking.
- Reset mid-operation: the edge with Reset=1 forces O=0 regardless of s. The first edge after Reset deasserts loads sel normally.
- Select changing every cycle: O follows with a 1-cycle lag, with no skipped or repeated values.
- Simultaneous change of s and data inputs before the same edge: O captures the new s applied to the new data.
- No arithmetic. Bits pass through unmodified and no sign or zero extension is performed (all widths equal).
- s containing X/Z in simulation: O <= X is acceptable. Synthesis is unaffected.

Decomposition:
- Shared package:
  - WIDTH default (16).
  - Select code constants SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2, SEL_D=2'd3.
- Natural sub-module: mux4 (combinational WIDTH-bit 4:1 selector), wrapped by mux4x16, which adds the output register and reset.
- No FSM required.

Test Plan:
- Reset: A=1, B=2, C=3, D=4, s=0, Reset=1 for one edge -> O=0 after that edge.
- Sweep select: Reset=0, A=1, B=2, C=3, D=4; apply s=0,1,2,3 on consecutive edges -> O=1,2,3,4 on those edges, each one cycle after its s is applied.
- Width and full data: A=16'hFFFF, B=16'h8001, C=16'h0000, D=16'h5A5A; sweep s -> O reproduces each word bit-exactly.
- Reset mid-stream: s=3 (O=4), then Reset=1 for one edge -> O=0; Reset=0 with s=1 -> next edge O=2.
- Registering check:
  - Change s from 0 to 2 midway between edges -> O stays 1 until the next rising edge, then becomes 3.
  - Change D while s=1 -> O unaffected (stays 2).
- Simultaneous update: before one edge set s=2 and C=16'h1234 together -> O=16'h1234 after that edge.
